rtc_time_reader: RTL and testbench
==================================

# rtc_time_reader

Periodic poller sitting directly upstream of the I2C master on the clock board. Every poll period it commands the master to write register pointer 0x00 to the RTC and read back three bytes (seconds, minutes, hours). It checks the handshake and BCD format, then publishes a validated BCD time to the display path. It owns the master's `start`, `nrOfBytesToSend`, `bytesToSend` and `nrOfBytesToRead` inputs, and consumes `bytesToRead`, `ready` and `clockStretchTimeoutReached`.

## Interface
- `ClockFrequency`, 1000000: clock frequency in Hz.
- `PollPeriodMs`, 100: interval between poll starts in ms; legal range 1..1000.
- `MaxBytesToSend`, 16: must match the I2C master.
- `MaxBytesToRead`, 16: must match the I2C master.
- `HandshakeTimeout`, 16: cycles allowed for the master to drop `ready` after `start`.

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `i2cStart`  out  1  one-cycle start pulse to the master.
- `i2cNrOfBytesToSend`  out  MaxBytesToSend  constant 1.
- `i2cBytesToSend`  out  MaxBytesToSend*8  packed, byte i at [8i+7:8i]; byte0 = 0x00, all other bytes 0.
- `i2cNrOfBytesToRead`  out  MaxBytesToRead  constant 3.
- `i2cBytesToRead`  in  MaxBytesToRead*8  byte0 = seconds, byte1 = minutes, byte2 = hours.
- `i2cReady`  in  1  master idle (high) or busy (low).
- `i2cTimeout`  in  1  master's clockStretchTimeoutReached.
- `seconds`  out  8  BCD 0x00–0x59.
- `minutes`  out  8  BCD 0x00–0x59.
- `hours`  out  8  BCD 0x00–0x23.
- `timeValid`  out  1  high once at least one good sample has been published.
- `clockHalted`  out  1  CH bit (seconds bit 7) of the last good sample.
- `formatError`  out  1  last transfer returned data that failed the format check.
- `busError`  out  1  last transfer ended with a handshake or stretch timeout.

## Operation
- Reset values: `i2cStart` = 0; `seconds`, `minutes`, `hours` = 0x00; `timeValid`, `clockHalted`, `formatError`, `busError` = 0. Constant outputs hold their constant value at all times, including during reset.
- States:
  - **WaitPeriod**: count down the poll counter. At 0, go to IssueStart.
  - **IssueStart**: entered only when `i2cReady` = 1; otherwise stay until it is. Assert `i2cStart` for exactly 1 cycle, load the handshake counter, go to WaitBusy.
  - **WaitBusy**: `i2cReady` = 0 → WaitDone. Counter expires (HandshakeTimeout cycles with `i2cReady` still 1) → set `busError`, go to WaitPeriod.
  - **WaitDone**: `i2cReady` = 1 → Decode. No watchdog in this state; the master's own stretch timeout bounds it.
  - **Decode** (1 cycle):
    - `i2cTimeout` = 1 → set `busError`; time outputs unchanged.
    - Otherwise clear `busError` and run the format check:
      - seconds and minutes masked to 7 bits; each low nibble ≤ 9, tens ≤ 5;
      - hours bit 6 = 0 (24 h mode only); hours masked to 6 bits with value ≤ 0x23 and low nibble ≤ 9.
    - Check fails → set `formatError`; time outputs unchanged.
    - Check passes → load the masked values, `clockHalted` = seconds bit 7, `timeValid` = 1, `formatError` = 0.
    - Then go to WaitPeriod.
- Poll counter: reloaded with ClockFrequency/1000*PollPeriodMs − 1 at each IssueStart. Period is measured start-to-start. If a transfer outlasts the period, the next start is issued as soon as WaitDone/Decode completes.
- After reset the counter starts at 0, so the first poll begins immediately.
- Reset asserted mid-transfer: FSM returns to WaitPeriod with the counter at 0, and all outputs take their reset values. The master is reset by the same signal.

## Timing
- `i2cStart`: high for exactly one cycle, in the cycle after entry to IssueStart. Never asserted while `i2cReady` = 0.
- Time outputs, `clockHalted`, `timeValid`, `formatError` and `busError` are registered. They change only on the clock edge that leaves Decode, one cycle after `i2cReady` is sampled high in WaitDone.
- `seconds`, `minutes` and `hours` update in the same cycle, so no torn time is ever visible.
- `i2cTimeout` is sampled only in Decode.

## Test plan
- **Normal read.** Reset, then a master model returns bytes 0x45, 0x30, 0x12 after 50 cycles busy → one `i2cStart` pulse, with `i2cBytesToSend` byte0 = 0x00. Outputs `seconds` = 0x45, `minutes` = 0x30, `hours` = 0x12, `timeValid` = 1, `clockHalted` = 0, both error flags 0.
- **Poll period.** ClockFrequency = 1000000, PollPeriodMs = 1 → consecutive `i2cStart` pulses exactly 1000 cycles apart.
- **Format reject.** After a good sample, the model returns 0x5A, 0x30, 0x12 → `formatError` = 1 and outputs stay at the prior values. With seconds = 0x80 and hours = 0x52, the sample is also rejected (12 h mode), with `clockHalted` unchanged.
- **Stretch timeout.** The model asserts `i2cTimeout` when returning `i2cReady` high → `busError` = 1 and outputs unchanged. The next good poll clears `busError` to 0.
- **Handshake timeout.** The model never drops `i2cReady` → `busError` = 1 after exactly 16 cycles, then the next start follows one period later.
- **Reset mid-transfer.** Assert reset during WaitDone → all outputs reset immediately. After release, `i2cStart` pulses within 2 cycles, and only once the model shows `i2cReady` = 1.

Source files
------------

// File: rtl/rtc_time_reader.sv
// Periodic RTC poller: drives the I2C master to read seconds/minutes/hours,
// validates the BCD format and publishes the time as one atomic update.
module rtc_time_reader #(
  parameter int ClockFrequency   = 1000000,
  parameter int PollPeriodMs     = 100,
  parameter int MaxBytesToSend   = 16,
  parameter int MaxBytesToRead   = 16,
  parameter int HandshakeTimeout = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        i2cStart,
  output logic [MaxBytesToSend-1:0]   i2cNrOfBytesToSend,
  output logic [MaxBytesToSend*8-1:0] i2cBytesToSend,
  output logic [MaxBytesToRead-1:0]   i2cNrOfBytesToRead,
  input  logic [MaxBytesToRead*8-1:0] i2cBytesToRead,
  input  logic                        i2cReady,
  input  logic                        i2cTimeout,
  output logic [7:0]                  seconds,
  output logic [7:0]                  minutes,
  output logic [7:0]                  hours,
  output logic                        timeValid,
  output logic                        clockHalted,
  output logic                        formatError,
  output logic                        busError
);

  localparam int PollCycles = ClockFrequency / 1000 * PollPeriodMs;
  localparam int PollWidth  = (PollCycles > 2) ? $clog2(PollCycles) : 1;
  localparam logic [PollWidth-1:0] PollReload = PollWidth'(PollCycles - 1);
  localparam int HsWidth    = (HandshakeTimeout > 2) ? $clog2(HandshakeTimeout) : 1;
  localparam logic [HsWidth-1:0] HsReload = HsWidth'(HandshakeTimeout - 1);

  typedef enum logic [2:0] {
    WAIT_PERIOD,
    ISSUE_START,
    WAIT_BUSY,
    WAIT_DONE,
    DECODE
  } state_t;

  state_t               state_q, state_d;
  logic [PollWidth-1:0] poll_cnt_q, poll_cnt_d;
  logic [HsWidth-1:0]   hs_cnt_q, hs_cnt_d;
  logic [7:0]           seconds_q, seconds_d;
  logic [7:0]           minutes_q, minutes_d;
  logic [7:0]           hours_q, hours_d;
  logic                 time_valid_q, time_valid_d;
  logic                 clock_halted_q, clock_halted_d;
  logic                 format_error_q, format_error_d;
  logic                 bus_error_q, bus_error_d;

  logic [7:0] sec_raw, min_raw, hr_raw;
  logic [6:0] sec_m, min_m;
  logic [5:0] hr_m;
  logic       sec_ok, min_ok, hr_ok, fmt_ok;
  logic       unused_bits;

  assign i2cNrOfBytesToSend = MaxBytesToSend'(1);
  assign i2cBytesToSend     = '0;
  assign i2cNrOfBytesToRead = MaxBytesToRead'(3);

  assign sec_raw = i2cBytesToRead[7:0];
  assign min_raw = i2cBytesToRead[15:8];
  assign hr_raw  = i2cBytesToRead[23:16];
  assign sec_m   = sec_raw[6:0];
  assign min_m   = min_raw[6:0];
  assign hr_m    = hr_raw[5:0];
  assign unused_bits = ^{i2cBytesToRead[MaxBytesToRead*8-1:24], min_raw[7], hr_raw[7]};

  assign sec_ok = (sec_m[3:0] <= 4'd9) && (sec_m[6:4] <= 3'd5);
  assign min_ok = (min_m[3:0] <= 4'd9) && (min_m[6:4] <= 3'd5);
  // Bit 6 set means the RTC is in 12 h mode, which the display cannot show.
  assign hr_ok  = !hr_raw[6] && (hr_m <= 6'h23) && (hr_m[3:0] <= 4'd9);
  assign fmt_ok = sec_ok && min_ok && hr_ok;

  // Gated by ready so a start can never reach a busy master.
  assign i2cStart    = (state_q == ISSUE_START) && i2cReady;
  assign seconds     = seconds_q;
  assign minutes     = minutes_q;
  assign hours       = hours_q;
  assign timeValid   = time_valid_q;
  assign clockHalted = clock_halted_q;
  assign formatError = format_error_q;
  assign busError    = bus_error_q;

  always_comb begin
    state_d        = state_q;
    poll_cnt_d     = (poll_cnt_q != '0) ? poll_cnt_q - PollWidth'(1) : poll_cnt_q;
    hs_cnt_d       = hs_cnt_q;
    seconds_d      = seconds_q;
    minutes_d      = minutes_q;
    hours_d        = hours_q;
    time_valid_d   = time_valid_q;
    clock_halted_d = clock_halted_q;
    format_error_d = format_error_q;
    bus_error_d    = bus_error_q;

    case (state_q)
      WAIT_PERIOD: begin
        if (poll_cnt_q == '0 && i2cReady) state_d = ISSUE_START;
      end
      ISSUE_START: begin
        if (i2cReady) begin
          state_d  = WAIT_BUSY;
          hs_cnt_d = HsReload;
        end
      end
      WAIT_BUSY: begin
        if (!i2cReady) begin
          state_d = WAIT_DONE;
        end else if (hs_cnt_q == '0) begin
          bus_error_d = 1'b1;
          state_d     = WAIT_PERIOD;
        end else begin
          hs_cnt_d = hs_cnt_q - HsWidth'(1);
        end
      end
      WAIT_DONE: begin
        if (i2cReady) state_d = DECODE;
      end
      DECODE: begin
        state_d = WAIT_PERIOD;
        if (i2cTimeout) begin
          bus_error_d = 1'b1;
        end else begin
          bus_error_d = 1'b0;
          if (!fmt_ok) begin
            format_error_d = 1'b1;
          end else begin
            seconds_d      = {1'b0, sec_m};
            minutes_d      = {1'b0, min_m};
            hours_d        = {2'b00, hr_m};
            clock_halted_d = sec_raw[7];
            time_valid_d   = 1'b1;
            format_error_d = 1'b0;
          end
        end
      end
      default: state_d = WAIT_PERIOD;
    endcase

    // Reloading while entering or waiting in ISSUE_START makes the period
    // measure start-to-start even if the master is briefly not ready.
    if (state_d == ISSUE_START) poll_cnt_d = PollReload;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_PERIOD;
      poll_cnt_q     <= '0;
      hs_cnt_q       <= '0;
      seconds_q      <= 8'h00;
      minutes_q      <= 8'h00;
      hours_q        <= 8'h00;
      time_valid_q   <= 1'b0;
      clock_halted_q <= 1'b0;
      format_error_q <= 1'b0;
      bus_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      poll_cnt_q     <= poll_cnt_d;
      hs_cnt_q       <= hs_cnt_d;
      seconds_q      <= seconds_d;
      minutes_q      <= minutes_d;
      hours_q        <= hours_d;
      time_valid_q   <= time_valid_d;
      clock_halted_q <= clock_halted_d;
      format_error_q <= format_error_d;
      bus_error_q    <= bus_error_d;
    end
  end

endmodule

// File: tb/tb_rtc_time_reader.sv
// Directed bench for rtc_time_reader with a 1000-cycle poll period and a
// task-based I2C master model.
module tb_rtc_time_reader;

  localparam int Period = 1000;

  logic         clock = 1'b0;
  logic         reset;
  logic         i2cStart;
  logic [15:0]  i2cNrOfBytesToSend;
  logic [127:0] i2cBytesToSend;
  logic [15:0]  i2cNrOfBytesToRead;
  logic [127:0] rd_bytes;
  logic         i2cReady;
  logic         i2cTimeout;
  logic [7:0]   seconds, minutes, hours;
  logic         timeValid, clockHalted, formatError, busError;

  rtc_time_reader #(
    .ClockFrequency(1000000), .PollPeriodMs(1), .MaxBytesToSend(16),
    .MaxBytesToRead(16), .HandshakeTimeout(16)
  ) dut (
    .clock(clock), .reset(reset), .i2cStart(i2cStart),
    .i2cNrOfBytesToSend(i2cNrOfBytesToSend), .i2cBytesToSend(i2cBytesToSend),
    .i2cNrOfBytesToRead(i2cNrOfBytesToRead), .i2cBytesToRead(rd_bytes),
    .i2cReady(i2cReady), .i2cTimeout(i2cTimeout),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .timeValid(timeValid), .clockHalted(clockHalted),
    .formatError(formatError), .busError(busError)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] sec, min, hr;
    logic       tmo;
    logic [7:0] e_sec, e_min, e_hr;
    logic       e_valid, e_ch, e_fmt, e_bus;
  } vec_t;

  vec_t vecs[10];
  vec_t last_vec;
  int   checks = 0;
  int   failures = 0;
  int   prev_start = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clock);
      if (i2cStart) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL start_seen: no i2cStart within 3000 cycles");
    end else begin
      if (prev_start >= 0) check("start_period", cyc - prev_start, Period);
      prev_start = cyc;
    end
  endtask

  // Master model from the cycle after the start pulse to published outputs.
  task automatic finish_transfer(input vec_t v, input string tag);
    int extra;
    extra = 0;
    @(negedge clock);
    check({tag, "_start_one_cycle"}, i2cStart, 1'b0);
    i2cReady   = 1'b0;
    i2cTimeout = 1'b0;
    for (int i = 0; i < 49; i++) begin
      @(negedge clock);
      if (i2cStart) extra++;
    end
    check({tag, "_start_while_busy"}, extra, 0);
    rd_bytes        = '0;
    rd_bytes[23:0]  = {v.hr, v.min, v.sec};
    i2cTimeout      = v.tmo;
    i2cReady        = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check({tag, "_seconds"}, seconds, v.e_sec);
    check({tag, "_minutes"}, minutes, v.e_min);
    check({tag, "_hours"}, hours, v.e_hr);
    check({tag, "_timeValid"}, timeValid, v.e_valid);
    check({tag, "_clockHalted"}, clockHalted, v.e_ch);
    check({tag, "_formatError"}, formatError, v.e_fmt);
    check({tag, "_busError"}, busError, v.e_bus);
    $display("%s: in %02h/%02h/%02h tmo=%0b -> out %02h:%02h:%02h v=%0b ch=%0b fe=%0b be=%0b",
             tag, v.sec, v.min, v.hr, v.tmo, hours, minutes, seconds,
             timeValid, clockHalted, formatError, busError);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_start"}, i2cStart, 1'b0);
    check({tag, "_seconds"}, seconds, 8'h00);
    check({tag, "_minutes"}, minutes, 8'h00);
    check({tag, "_hours"}, hours, 8'h00);
    check({tag, "_timeValid"}, timeValid, 1'b0);
    check({tag, "_clockHalted"}, clockHalted, 1'b0);
    check({tag, "_formatError"}, formatError, 1'b0);
    check({tag, "_busError"}, busError, 1'b0);
    check({tag, "_nrSend"}, i2cNrOfBytesToSend, 16'd1);
    check({tag, "_nrRead"}, i2cNrOfBytesToRead, 16'd3);
    check({tag, "_send_byte0"}, i2cBytesToSend[7:0], 8'h00);
    check({tag, "_send_rest"}, |i2cBytesToSend[127:8], 1'b0);
  endtask

  initial begin
    bit ok;
    int seen;

    //            sec    min    hr   tmo  e_sec  e_min  e_hr  v ch fe be
    vecs[0] = '{8'h45, 8'h30, 8'h12, 1'b0, 8'h45, 8'h30, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h5A, 8'h30, 8'h12, 1'b0, 8'h45, 8'h30, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h00, 8'h52, 1'b0, 8'h45, 8'h30, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hD9, 8'h59, 8'h23, 1'b0, 8'h59, 8'h59, 8'h23, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 8'h08, 1'b1, 8'h59, 8'h59, 8'h23, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h60, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h59, 8'h59, 8'h24, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h01, 8'h02, 8'h1A, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{8'h07, 8'h88, 8'hA3, 1'b0, 8'h07, 8'h08, 8'h23, 1'b1, 1'b0, 1'b0, 1'b0};
    last_vec = '{8'h45, 8'h30, 8'h12, 1'b0, 8'h45, 8'h30, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0};

    reset      = 1'b1;
    i2cReady   = 1'b1;
    i2cTimeout = 1'b0;
    rd_bytes   = '0;
    repeat (3) @(negedge clock);
    check_reset_state("reset");
    $display("reset: outputs checked while reset held");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      wait_start(ok);
      finish_transfer(vecs[i], $sformatf("vec%0d", i));
    end

    // Master never acknowledges the start.
    wait_start(ok);
    for (int i = 1; i <= 16; i++) @(negedge clock);
    check("hs_bus_at_16", busError, 1'b0);
    @(negedge clock);
    check("hs_bus_at_17", busError, 1'b1);
    check("hs_seconds_kept", seconds, 8'h07);
    $display("handshake: busError=%0b after 17 cycles, seconds=%02h", busError, seconds);

    wait_start(ok);
    finish_transfer(last_vec, "recover");

    // Reset while the master is busy in the middle of a transfer.
    wait_start(ok);
    @(negedge clock);
    i2cReady = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    prev_start = -1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i2cStart) seen++;
    end
    check("midreset_no_start_busy", seen, 0);
    i2cReady = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2 && !ok; i++) begin
      @(negedge clock);
      if (i2cStart) ok = 1'b1;
    end
    check("midreset_start_within_2", ok, 1'b1);
    $display("midreset: start after ready=%0b", ok);
    if (ok) finish_transfer(last_vec, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
